// File: rtl/demux1x8_deser_pkg.sv
// Shared constants for the 1-to-8 serial demultiplexer/deserializer.
package demux1x8_deser_pkg;

    localparam int unsigned NLANES = 8;
    localparam int unsigned SLOT_W = 3;

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NLANES - 1);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] COLLECT = 1'b1;

endpackage

// File: rtl/demux1x8_deser_slot_decoder.sv
// 3-to-8 one-hot slot decode with enable: onehot_o[k] = en_i & (s_i == k).
module demux1x8_deser_slot_decoder
    import demux1x8_deser_pkg::*;
(
    input  logic              en_i,
    input  logic [SLOT_W-1:0] s_i,
    output logic [NLANES-1:0] onehot_o
);

    logic [SLOT_W-1:0] s_n;

    not u_n0 (s_n[0], s_i[0]);
    not u_n1 (s_n[1], s_i[1]);
    not u_n2 (s_n[2], s_i[2]);

    and u_a0 (onehot_o[0], en_i, s_n[2],  s_n[1],  s_n[0]);
    and u_a1 (onehot_o[1], en_i, s_n[2],  s_n[1],  s_i[0]);
    and u_a2 (onehot_o[2], en_i, s_n[2],  s_i[1],  s_n[0]);
    and u_a3 (onehot_o[3], en_i, s_n[2],  s_i[1],  s_i[0]);
    and u_a4 (onehot_o[4], en_i, s_i[2],  s_n[1],  s_n[0]);
    and u_a5 (onehot_o[5], en_i, s_i[2],  s_n[1],  s_i[0]);
    and u_a6 (onehot_o[6], en_i, s_i[2],  s_i[1],  s_n[0]);
    and u_a7 (onehot_o[7], en_i, s_i[2],  s_i[1],  s_i[0]);

endmodule

// File: rtl/demux1x8_deser.sv
// 1-to-8 time-division demultiplexer: collects slot bits 0..7 into a word
// and presents it with a valid/ready handshake plus overrun/resync pulses.
module demux1x8_deser
    import demux1x8_deser_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              frame,
    input  logic              din,
    input  logic              ready,
    output logic [0:NLANES-1] d,
    output logic              valid,
    output logic [SLOT_W-1:0] s,
    output logic              overrun,
    output logic              sync_err
);

    logic [0:0]        state_q, state_d;
    logic [SLOT_W-1:0] s_q, s_d;
    logic [0:NLANES-1] shadow_q, shadow_d;
    logic [0:NLANES-1] d_q, d_d;
    logic              valid_q, valid_d;
    logic              overrun_q, overrun_d;
    logic              sync_err_q, sync_err_d;

    logic              lane_en;
    logic [SLOT_W-1:0] lane_sel;
    logic [NLANES-1:0] lane_we;

    // A frame bit always lands in lane 0, whatever slot was pending.
    assign lane_en  = en & (frame | (state_q == COLLECT));
    assign lane_sel = frame ? '0 : s_q;

    demux1x8_deser_slot_decoder u_slot_decoder (
        .en_i     (lane_en),
        .s_i      (lane_sel),
        .onehot_o (lane_we)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            s_q        <= '0;
            shadow_q   <= '0;
            d_q        <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            s_q        <= s_d;
            shadow_q   <= shadow_d;
            d_q        <= d_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
            sync_err_q <= sync_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        s_d        = s_q;
        shadow_d   = shadow_q;
        d_d        = d_q;
        valid_d    = valid_q;
        overrun_d  = 1'b0;
        sync_err_d = 1'b0;

        if (valid_q && ready) begin
            valid_d = 1'b0;
        end

        if (en && frame) begin
            sync_err_d = (state_q == COLLECT);
            shadow_d   = '0;
            s_d        = SLOT_W'(1);
            state_d    = COLLECT;
        end else if (en && (state_q == COLLECT)) begin
            s_d = s_q + SLOT_W'(1);
            if (s_q == LAST_SLOT) begin
                state_d = IDLE;
                // A held word blocks the new one unless it is consumed now.
                if (valid_q && !ready) begin
                    overrun_d = 1'b1;
                end else begin
                    d_d     = {shadow_q[0:NLANES-2], din};
                    valid_d = 1'b1;
                end
            end
        end

        for (int unsigned k = 0; k < NLANES; k++) begin
            if (lane_we[k]) begin
                shadow_d[k] = din;
            end
        end
    end

    assign d        = d_q;
    assign valid    = valid_q;
    assign s        = s_q;
    assign overrun  = overrun_q;
    assign sync_err = sync_err_q;

endmodule

// File: tb/tb_demux1x8_deser.sv
// Directed and randomized bench for demux1x8_deser against a word-level model.
module tb_demux1x8_deser;

    logic       clk;
    logic       rst;
    logic       en;
    logic       frame;
    logic       din;
    logic       ready;
    logic [0:7] d;
    logic       valid;
    logic [2:0] s;
    logic       overrun;
    logic       sync_err;

    int checks;
    int failures;

    // Reference model: bits gathered so far in the current word (0 = idle).
    int         m_pos;
    logic [0:7] m_buf;
    logic [0:7] m_d;
    logic       m_valid;
    logic       m_over;
    logic       m_sync;

    demux1x8_deser dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .frame    (frame),
        .din      (din),
        .ready    (ready),
        .d        (d),
        .valid    (valid),
        .s        (s),
        .overrun  (overrun),
        .sync_err (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".d"},        8'(d),        8'(m_d));
        check({tag, ".valid"},    8'(valid),    8'(m_valid));
        check({tag, ".s"},        8'(s),        8'(m_pos % 8));
        check({tag, ".overrun"},  8'(overrun),  8'(m_over));
        check({tag, ".sync_err"}, 8'(sync_err), 8'(m_sync));
    endtask

    function automatic void model_reset();
        m_pos   = 0;
        m_buf   = '0;
        m_d     = '0;
        m_valid = 1'b0;
        m_over  = 1'b0;
        m_sync  = 1'b0;
    endfunction

    function automatic void model_step(input logic e, input logic f, input logic b, input logic r);
        logic had_valid;
        had_valid = m_valid;
        m_over    = 1'b0;
        m_sync    = 1'b0;
        if (had_valid && r) m_valid = 1'b0;
        if (e && f) begin
            m_sync   = (m_pos != 0);
            m_buf    = '0;
            m_buf[0] = b;
            m_pos    = 1;
        end else if (e && m_pos != 0) begin
            m_buf[m_pos] = b;
            m_pos++;
            if (m_pos == 8) begin
                m_pos = 0;
                if (had_valid && !r) begin
                    m_over = 1'b1;
                end else begin
                    m_d     = m_buf;
                    m_valid = 1'b1;
                end
            end
        end
    endfunction

    task automatic apply(input string tag, input logic e, input logic f, input logic b, input logic r);
        @(negedge clk);
        en = e; frame = f; din = b; ready = r;
        @(posedge clk);
        model_step(e, f, b, r);
        #1;
        check_all(tag);
    endtask

    task automatic send_word(input string tag, input logic [0:7] bits, input logic ready_last,
                             input bit gapped);
        for (int i = 0; i < 8; i++) begin
            apply(tag, 1'b1, (i == 0), bits[i], (i == 7) ? ready_last : 1'b0);
            if (gapped && i < 7) begin
                int n;
                n = int'($urandom_range(3, 1));
                for (int g = 0; g < n; g++) apply({tag, ".gap"}, 1'b0, 1'b0, 1'($urandom), 1'b0);
            end
        end
    endtask

    task automatic async_reset(input string tag);
        @(negedge clk);
        en = 1'b0; frame = 1'b0; ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        checks = 0; failures = 0;
        en = 1'b0; frame = 1'b0; din = 1'b0; ready = 1'b0;
        rst = 1'b0;
        model_reset();
        #3 rst = 1'b1;
        #1 check_all("por");
        @(negedge clk);
        rst = 1'b0;

        // Single frame, no consumer.
        send_word("single", 8'b10110010, 1'b0, 1'b0);
        check("single.word", 8'(d), 8'b10110010);
        check("single.s0", 8'(s), 8'd0);

        // Consume, then gapped frame, idle, consume again.
        apply("consume1", 1'b0, 1'b0, 1'b0, 1'b1);
        check("consume1.valid", 8'(valid), 8'd0);
        send_word("gapped", 8'b10110010, 1'b0, 1'b1);
        check("gapped.word", 8'(d), 8'b10110010);
        apply("hold", 1'b0, 1'b0, 1'b0, 1'b0);
        apply("consume2", 1'b0, 1'b0, 1'b0, 1'b1);
        check("consume2.valid", 8'(valid), 8'd0);
        check("consume2.dkeep", 8'(d), 8'b10110010);

        // Overrun: second word dropped while the first is held.
        send_word("ovr1", 8'b11110000, 1'b0, 1'b0);
        send_word("ovr2", 8'b00001111, 1'b0, 1'b0);
        check("ovr.pulse", 8'(overrun), 8'd1);
        check("ovr.dkeep", 8'(d), 8'b11110000);
        apply("ovr.after", 1'b0, 1'b0, 1'b0, 1'b0);
        check("ovr.once", 8'(overrun), 8'd0);

        // Consume and load in the same cycle.
        send_word("both", 8'b00001111, 1'b1, 1'b0);
        check("both.word", 8'(d), 8'b00001111);
        check("both.noovr", 8'(overrun), 8'd0);
        check("both.valid", 8'(valid), 8'd1);

        // Resync at slot 4.
        apply("drain", 1'b0, 1'b0, 1'b0, 1'b1);
        apply("rs.f", 1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) apply("rs.b", 1'b1, 1'b0, 1'b1, 1'b0);
        check("rs.s4", 8'(s), 8'd4);
        apply("rs.frame", 1'b1, 1'b1, 1'b0, 1'b0);
        check("rs.pulse", 8'(sync_err), 8'd1);
        for (int i = 1; i < 8; i++) apply("rs.rest", 1'b1, 1'b0, 1'((i % 2) == 1), 1'b0);
        check("rs.word", 8'(d), 8'b01010101);

        // Stray bits in idle.
        for (int i = 0; i < 4; i++) apply("stray", 1'b1, 1'b0, 1'($urandom), 1'b0);
        check("stray.s", 8'(s), 8'd0);

        // Reset mid-word and while a word is held.
        apply("mid.f", 1'b1, 1'b1, 1'b1, 1'b0);
        apply("mid.b", 1'b1, 1'b0, 1'b1, 1'b0);
        async_reset("midrst");
        for (int i = 0; i < 6; i++) apply("mid.noframe", 1'b1, 1'b0, 1'b1, 1'b0);
        check("mid.idle", 8'(valid), 8'd0);

        // Randomized traffic, with one asynchronous reset partway through.
        for (int c = 0; c < 600; c++) begin
            if (c == 300) async_reset("rnd.rst");
            apply("rnd", 1'($urandom_range(9, 0) < 7), 1'($urandom_range(9, 0) == 0),
                  1'($urandom), 1'($urandom_range(9, 0) < 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
